shift_pipe: RTL
===============

Name: shift_pipe

Overview:
Parametrised, pipelined barrel shifter. It succeeds the fixed combinational shift-by-2 used in branch-target generation, and it covers logical left, logical right, arithmetic right and rotate-left by any amount. It sits between the ID/EX operand latches and the ALU result mux. A valid/ready handshake allows the EX stage to stall it. The tag field carries the destination register alongside the data.

Parameters:
WIDTH, 32, data width in bits; must be a power of two and at least 4.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.
TAG_W, 5, width of the sideband tag passed through unchanged.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of the beat in out_data

Behaviour:
- Reset: asserting rst_n low clears every stage valid bit immediately, with no clock required.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 while reset is asserted and on the first cycle after release.
  - Beats already in flight are discarded; none reappear after reset.
- Pipeline: SHAMT_W register stages (5 for WIDTH=32). Stage k shifts by 2^k when shamt bit k is set.
  - Each stage registers data, op, tag, remaining shamt bits and a valid bit.
  - Latency from accept to out_valid is exactly SHAMT_W cycles when out_ready is held high.
- Handshake:
  - advance = !out_valid || out_ready, with out_valid taken from the last stage.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds data and valid. No beat is lost or duplicated.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - Throughput is one beat per cycle with no bubbles while out_ready=1.
  - out_data and out_tag are stable whenever out_valid=1 && out_ready=0.
- Arithmetic:
  - SLL: zeros fill from the LSB.
  - SRL: zeros fill from the MSB.
  - SRA: the sign bit is the MSB of the original in_data. It is captured at stage 0 and carried through the pipeline.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - Right shifts are implemented as bit-reverse, left shift, bit-reverse. The reversal happens at the stage 0 input and the last stage output. The fill bit is 0 or the carried sign bit.
- Boundaries:
  - shamt=0 returns in_data unchanged for all ops.
  - shamt=WIDTH-1 is the maximum. Shift amounts of WIDTH or more cannot be represented.
  - Simultaneous accept and drain in the same cycle is legal, and the pipeline stays full.
  - Bubbles are not collapsed during a stall. A stall freezes the whole pipe.
- Reset mid-operation follows the reset rule above.

Decomposition:
- Package shift_pkg holds localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11, plus a bit-reverse function.
- Sub-module shift_stage, with parameters WIDTH, TAG_W and DIST. It takes data, fill, op and valid plus an enable and performs one conditional shift by DIST with its register.
- shift_pipe instantiates shift_stage SHAMT_W times in a generate loop with DIST=2^k.

Test Plan:
- Reset then single beat:
  - Stimulus: in_data=32'h0000_0001, shamt=2, op=SLL, tag=3.
  - Required: out_valid exactly 5 cycles later, out_data=32'h0000_0004, out_tag=3.
- SRA sign fill:
  - Stimulus: in_data=32'h8000_00F0, shamt=4.
  - Required: 32'hF800_000F.
  - Stimulus: same data with op=SRL.
  - Required: 32'h0800_000F.
- ROL wrap:
  - Stimulus: in_data=32'hC000_0001, shamt=2.
  - Required: 32'h0000_0007.
  - Stimulus: shamt=31.
  - Required: 32'hE000_0000.
- Back-pressure:
  - Stimulus: stream 8 beats with data=i and shamt=i, op SLL, tags 0..7. Hold out_ready=0 for cycles 3–9, then release.
  - Required: in_ready=0 while the pipe is full and stalled. All 8 results arrive in order, out_data = i<<i. No drops or duplicates, and out_data stays stable during the stall.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 asynchronously (between clock edges) while 3 beats are in flight.
  - Required: out_valid falls immediately, no old beat appears after release, and the next beat's latency is again 5 cycles.
- Full-throughput random: 1000 random beats with out_ready=1, checked against a reference model. Required: one result per cycle after the initial 5-cycle fill.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared opcodes and the bit-reverse helper for the pipelined barrel shifter.
// Right shifts are done by reversing the operand, shifting left, and reversing the result back.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // Widest operand the reverse helper supports.
  localparam int MAX_WIDTH = 64;
  localparam int IDX_W     = 6;

  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] v, input int w);
    logic [MAX_WIDTH-1:0] r;
    r = {MAX_WIDTH{1'b0}};
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) begin
        r[IDX_W'(i)] = v[IDX_W'(w - 1 - i)];
      end else begin
        r[IDX_W'(i)] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic is_right(input logic [1:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: shifts left (or rotates) by DIST when its shamt bit is set.
// The last stage also undoes the operand reversal for right shifts before registering.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int DIST    = 1,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter bit LAST    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_fill,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_fill,
  output logic [1:0]         out_op,
  output logic [TAG_W-1:0]   out_tag,
  output logic [SHAMT_W-1:0] out_shamt
);

  localparam int BIT = $clog2(DIST);
  localparam logic [WIDTH-1:0] FILL_MASK = {WIDTH{1'b1}} >> (WIDTH - DIST);

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] next_data_s;

  // Conditional shift by DIST, then restore bit order on the final stage of a right shift.
  always_comb begin
    shifted_s   = in_data;
    next_data_s = in_data;
    if (in_shamt[BIT]) begin
      if (in_op == OP_ROL) begin
        shifted_s = (in_data << DIST) | (in_data >> (WIDTH - DIST));
      end else if (in_fill) begin
        shifted_s = (in_data << DIST) | FILL_MASK;
      end else begin
        shifted_s = in_data << DIST;
      end
    end else begin
      shifted_s = in_data;
    end
    if (LAST && is_right(in_op)) begin
      next_data_s = WIDTH'(bit_rev(MAX_WIDTH'(shifted_s), WIDTH));
    end else begin
      next_data_s = shifted_s;
    end
  end

  // Stage register; holds everything, bubbles included, while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_fill  <= 1'b0;
      out_op    <= 2'b00;
      out_tag   <= {TAG_W{1'b0}};
      out_shamt <= {SHAMT_W{1'b0}};
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= next_data_s;
      out_fill  <= in_fill;
      out_op    <= in_op;
      out_tag   <= in_tag;
      out_shamt <= in_shamt;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with a valid/ready handshake and a tag sideband.
// One stage per shift-amount bit; the whole pipe freezes when the consumer stalls.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic               advance_s;
  logic               valid_s [0:SHAMT_W];
  logic [WIDTH-1:0]   data_s  [0:SHAMT_W];
  logic               fill_s  [0:SHAMT_W];
  logic [1:0]         op_s    [0:SHAMT_W];
  logic [TAG_W-1:0]   tag_s   [0:SHAMT_W];
  logic [SHAMT_W-1:0] shamt_s [0:SHAMT_W];
  logic               unused_s;

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  // Stage 0 input: reverse right-shift operands and capture the sign for SRA fill.
  assign valid_s[0] = in_valid;
  assign data_s[0]  = is_right(in_op) ? WIDTH'(bit_rev(MAX_WIDTH'(in_data), WIDTH)) : in_data;
  assign fill_s[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];
  assign op_s[0]    = in_op;
  assign tag_s[0]   = in_tag;
  assign shamt_s[0] = in_shamt;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .DIST    (1 << k),
      .SHAMT_W (SHAMT_W),
      .LAST    (k == SHAMT_W - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance_s),
      .in_valid  (valid_s[k]),
      .in_data   (data_s[k]),
      .in_fill   (fill_s[k]),
      .in_op     (op_s[k]),
      .in_tag    (tag_s[k]),
      .in_shamt  (shamt_s[k]),
      .out_valid (valid_s[k+1]),
      .out_data  (data_s[k+1]),
      .out_fill  (fill_s[k+1]),
      .out_op    (op_s[k+1]),
      .out_tag   (tag_s[k+1]),
      .out_shamt (shamt_s[k+1])
    );
  end

  assign out_valid = valid_s[SHAMT_W];
  assign out_data  = data_s[SHAMT_W];
  assign out_tag   = tag_s[SHAMT_W];

  // Control fields of the final stage are not needed past the pipe.
  assign unused_s = ^{fill_s[SHAMT_W], op_s[SHAMT_W], shamt_s[SHAMT_W]};

endmodule
